// File: rtl/pmem_arbiter_if.sv
// Request/response bundle between the cache layer, the write buffer and main memory.
// The arbiter uses the slave view; the environment (caches, buffer, memory) uses master.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic                  icache_resp;
  logic [LINE_WIDTH-1:0] icache_rdata;

  logic                  dcache_read;
  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic                  dcache_resp;
  logic [LINE_WIDTH-1:0] dcache_rdata;

  logic                  ewb_write;
  logic [ADDR_WIDTH-1:0] ewb_addr;
  logic [LINE_WIDTH-1:0] ewb_wdata;
  logic                  ewb_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  icache_read, icache_addr, dcache_read, dcache_addr,
           ewb_write, ewb_addr, ewb_wdata, pmem_rdata, pmem_resp,
    output icache_resp, icache_rdata, dcache_resp, dcache_rdata,
           ewb_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output icache_read, icache_addr, dcache_read, dcache_addr,
           ewb_write, ewb_addr, ewb_wdata, pmem_rdata, pmem_resp,
    input  icache_resp, icache_rdata, dcache_resp, dcache_rdata,
           ewb_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical memory port between I-cache fill, D-cache fill and write-back,
// with round-robin between reads, a write-before-fill hazard rule and a starvation bound.
module pmem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IREAD = 2'd1,
    S_DREAD = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  logic       rr_d, rr_d_next;
  logic [3:0] starve_cnt, starve_cnt_next;

  logic hazard;
  logic starved;
  logic both_reads;
  logic read_grant;

  // A buffered line that the D-cache wants back must reach memory before the fill.
  assign hazard     = bus.ewb_write && bus.dcache_read && (bus.dcache_addr == bus.ewb_addr);
  assign starved    = bus.ewb_write && (starve_cnt >= STARVE_MAX);
  assign both_reads = bus.icache_read && bus.dcache_read;
  assign read_grant = (state == S_IDLE) && ((state_next == S_IREAD) || (state_next == S_DREAD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_d       <= 1'b1;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      rr_d       <= rr_d_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    rr_d_next        = rr_d;
    starve_cnt_next  = starve_cnt;
    bus.icache_resp  = 1'b0;
    bus.icache_rdata = '0;
    bus.dcache_resp  = 1'b0;
    bus.dcache_rdata = '0;
    bus.ewb_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;

    unique case (state)
      S_IDLE: begin
        if (hazard || starved) begin
          state_next = S_WB;
        end else if (both_reads) begin
          state_next = rr_d ? S_DREAD : S_IREAD;
          rr_d_next  = ~rr_d;
        end else if (bus.dcache_read) begin
          state_next = S_DREAD;
        end else if (bus.icache_read) begin
          state_next = S_IREAD;
        end else if (bus.ewb_write) begin
          state_next = S_WB;
        end
      end

      S_IREAD: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = bus.icache_addr;
        if (bus.pmem_resp) begin
          bus.icache_resp  = 1'b1;
          bus.icache_rdata = bus.pmem_rdata;
          state_next       = S_IDLE;
        end
      end

      S_DREAD: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = bus.dcache_addr;
        if (bus.pmem_resp) begin
          bus.dcache_resp  = 1'b1;
          bus.dcache_rdata = bus.pmem_rdata;
          state_next       = S_IDLE;
        end
      end

      S_WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = bus.ewb_addr;
        bus.pmem_wdata   = bus.ewb_wdata;
        if (bus.pmem_resp) begin
          bus.ewb_resp = 1'b1;
          state_next   = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Each read that overtakes a waiting write-back counts toward forcing it.
    if ((state == S_IDLE) && (state_next == S_WB)) begin
      starve_cnt_next = 4'd0;
    end else if (read_grant && bus.ewb_write && (starve_cnt != 4'hF)) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized request mixes
// compared against a grant-rule model of the arbiter.
`timescale 1ns/1ps
module tb_pmem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int SL = 4;
  localparam int G_NONE = 0, G_I = 1, G_D = 2, G_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;
  int both_viol = 0;
  int rdata_viol = 0;

  // Model state: which read is favoured, and how many reads overtook a waiting write.
  bit m_fav_d;
  int m_bypass;

  always @(negedge clk) begin
    if (bus.pmem_read && bus.pmem_write) both_viol++;
    if ((!bus.icache_resp && bus.icache_rdata != '0) || (!bus.dcache_resp && bus.dcache_rdata != '0))
      rdata_viol++;
  end

  function automatic int predict(bit i, bit d, bit w, logic [AW-1:0] da, logic [AW-1:0] wa);
    if (w && d && da == wa) return G_W;
    if (w && m_bypass >= SL) return G_W;
    if (i && d) return m_fav_d ? G_D : G_I;
    if (d) return G_D;
    if (i) return G_I;
    if (w) return G_W;
    return G_NONE;
  endfunction

  task automatic model_update(int g, bit i, bit d, bit w);
    if (g == G_W) m_bypass = 0;
    else begin
      if (w && m_bypass < 15) m_bypass++;
      if (i && d) m_fav_d = (g == G_I);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 16'h4000;
      1: return 16'h4010;
      default: return 16'($urandom) & 16'hFFF0;
    endcase
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_idle();
    bus.icache_read = 0; bus.icache_addr = '0;
    bus.dcache_read = 0; bus.dcache_addr = '0;
    bus.ewb_write = 0; bus.ewb_addr = '0; bus.ewb_wdata = '0;
    bus.pmem_resp = 0; bus.pmem_rdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_fav_d = 1;
    m_bypass = 0;
  endtask

  // Plays memory for one transaction: waits for a strobe, holds lat cycles, then pulses pmem_resp.
  // Called from just after a rising edge with the requests already applied; returns likewise.
  task automatic serve(input int lat, input logic [LW-1:0] rd,
                       output int waited, output logic o_rd, output logic o_wr,
                       output logic [AW-1:0] o_addr, output logic [LW-1:0] o_wdata,
                       output int g, output int nresp,
                       output logic [LW-1:0] o_irdata, output logic [LW-1:0] o_drdata,
                       output bit stable, output bit to);
    waited = 0; to = 0; stable = 1; g = G_NONE; nresp = 0;
    o_rd = 0; o_wr = 0; o_addr = '0; o_wdata = '0; o_irdata = '0; o_drdata = '0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(bus.pmem_read || bus.pmem_write) && waited < 20);
    if (!(bus.pmem_read || bus.pmem_write)) begin
      to = 1;
      @(posedge clk); #1;
      return;
    end
    o_rd = bus.pmem_read; o_wr = bus.pmem_write;
    o_addr = bus.pmem_address; o_wdata = bus.pmem_wdata;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (bus.pmem_read !== o_rd || bus.pmem_write !== o_wr || bus.pmem_address !== o_addr ||
          bus.pmem_wdata !== o_wdata || bus.icache_resp || bus.dcache_resp || bus.ewb_resp)
        stable = 0;
    end
    @(posedge clk); #1;
    bus.pmem_resp = 1; bus.pmem_rdata = rd;
    @(negedge clk);
    nresp = int'(bus.icache_resp) + int'(bus.dcache_resp) + int'(bus.ewb_resp);
    g = bus.ewb_resp ? G_W : bus.dcache_resp ? G_D : bus.icache_resp ? G_I : G_NONE;
    o_irdata = bus.icache_rdata; o_drdata = bus.dcache_rdata;
    @(posedge clk); #1;
    bus.pmem_resp = 0; bus.pmem_rdata = rand_line();
  endtask

  task automatic test_reset();
    reset = 1;
    bus.icache_read = 1; bus.ewb_write = 1; bus.ewb_wdata = rand_line(); bus.pmem_resp = 1;
    @(negedge clk);
    checks++; if (bus.pmem_read !== 0 || bus.pmem_write !== 0) $display("FAIL reset_strobes got=%b%b exp=00", bus.pmem_read, bus.pmem_write); else passes++;
    checks++; if (bus.pmem_address !== '0 || bus.pmem_wdata !== '0) $display("FAIL reset_bus got addr=%h exp=0", bus.pmem_address); else passes++;
    checks++; if ({bus.icache_resp, bus.dcache_resp, bus.ewb_resp} !== 3'b000) $display("FAIL reset_resp got=%b exp=000", {bus.icache_resp, bus.dcache_resp, bus.ewb_resp}); else passes++;
    checks++; if (dut.rr_d !== 1'b1 || dut.starve_cnt !== 4'd0) $display("FAIL reset_regs got rr_d=%b starve=%0d exp=1,0", dut.rr_d, dut.starve_cnt); else passes++;
    do_reset();
    @(negedge clk);
    checks++; if (bus.pmem_read !== 0 || bus.pmem_write !== 0) $display("FAIL idle_after_reset got=%b%b exp=00", bus.pmem_read, bus.pmem_write); else passes++;
    $display("test_reset done");
  endtask

  task automatic test_single_iread();
    int waited, g, nresp; logic o_rd, o_wr; logic [AW-1:0] o_addr; logic [LW-1:0] o_wd, ird, drd; bit st, to;
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    do_reset();
    bus.icache_read = 1; bus.icache_addr = 16'h1230;
    serve(2, a5, waited, o_rd, o_wr, o_addr, o_wd, g, nresp, ird, drd, st, to);
    bus.icache_read = 0;
    checks++; if (to || waited !== 2) $display("FAIL iread_latency got=%0d exp=2", waited); else passes++;
    checks++; if (o_rd !== 1 || o_wr !== 0 || o_addr !== 16'h1230) $display("FAIL iread_bus got rd=%b addr=%h exp rd=1 addr=1230", o_rd, o_addr); else passes++;
    checks++; if (g !== G_I || nresp !== 1) $display("FAIL iread_resp got g=%0d n=%0d exp g=%0d n=1", g, nresp, G_I); else passes++;
    checks++; if (ird !== a5) $display("FAIL iread_rdata got=%h exp=%h", ird, a5); else passes++;
    checks++; if (!st) $display("FAIL iread_stable got=0 exp=1"); else passes++;
    @(negedge clk);
    checks++; if (bus.pmem_read !== 0 || dut.rr_d !== 1'b1) $display("FAIL iread_idle got rd=%b rr_d=%b exp 0,1", bus.pmem_read, dut.rr_d); else passes++;
    $display("test_single_iread done g=%0d addr=%h", g, o_addr);
  endtask

  task automatic test_round_robin();
    int waited, g, nresp, exp; logic o_rd, o_wr; logic [AW-1:0] o_addr; logic [LW-1:0] o_wd, ird, drd, rd; bit st, to;
    int seq [3] = '{G_D, G_I, G_D};
    do_reset();
    bus.icache_read = 1; bus.icache_addr = 16'h1000;
    bus.dcache_read = 1; bus.dcache_addr = 16'h2000;
    for (int k = 0; k < 3; k++) begin
      exp = predict(1, 1, 0, bus.dcache_addr, bus.ewb_addr);
      rd = rand_line();
      serve($urandom_range(0, 3), rd, waited, o_rd, o_wr, o_addr, o_wd, g, nresp, ird, drd, st, to);
      model_update(exp, 1, 1, 0);
      checks++; if (to || g !== seq[k] || g !== exp) $display("FAIL rr_grant%0d got=%0d exp=%0d", k, g, seq[k]); else passes++;
      checks++; if (o_addr !== (seq[k] == G_D ? 16'h2000 : 16'h1000)) $display("FAIL rr_addr%0d got=%h", k, o_addr); else passes++;
      checks++; if (dut.rr_d !== m_fav_d) $display("FAIL rr_ptr%0d got=%b exp=%b", k, dut.rr_d, m_fav_d); else passes++;
      $display("rr txn %0d grant=%0d addr=%h", k, g, o_addr);
    end
    drive_idle();
  endtask

  task automatic test_hazard();
    int waited, g, nresp; logic o_rd, o_wr; logic [AW-1:0] o_addr; logic [LW-1:0] o_wd, ird, drd, wd, rd; bit st, to;
    do_reset();
    wd = rand_line();
    bus.ewb_write = 1; bus.ewb_addr = 16'h4000; bus.ewb_wdata = wd;
    bus.dcache_read = 1; bus.dcache_addr = 16'h4000;
    serve(1, rand_line(), waited, o_rd, o_wr, o_addr, o_wd, g, nresp, ird, drd, st, to);
    bus.ewb_write = 0;
    checks++; if (to || g !== G_W || o_wr !== 1 || o_rd !== 0) $display("FAIL hazard_first got g=%0d wr=%b exp g=%0d wr=1", g, o_wr, G_W); else passes++;
    checks++; if (o_addr !== 16'h4000 || o_wd !== wd) $display("FAIL hazard_wdata got addr=%h data=%h exp 4000 %h", o_addr, o_wd, wd); else passes++;
    rd = rand_line();
    serve(2, rd, waited, o_rd, o_wr, o_addr, o_wd, g, nresp, ird, drd, st, to);
    bus.dcache_read = 0;
    checks++; if (to || g !== G_D || o_addr !== 16'h4000 || drd !== rd) $display("FAIL hazard_fill got g=%0d addr=%h exp g=%0d addr=4000", g, o_addr, G_D); else passes++;
    $display("test_hazard done");
  endtask

  task automatic test_starvation();
    int waited, g, nresp; logic o_rd, o_wr; logic [AW-1:0] o_addr; logic [LW-1:0] o_wd, ird, drd; bit st, to;
    int seq [5] = '{G_D, G_I, G_D, G_I, G_W};
    do_reset();
    bus.ewb_write = 1; bus.ewb_addr = 16'h8000; bus.ewb_wdata = rand_line();
    bus.icache_read = 1; bus.icache_addr = 16'h1000;
    bus.dcache_read = 1; bus.dcache_addr = 16'h2000;
    for (int k = 0; k < 5; k++) begin
      serve($urandom_range(0, 2), rand_line(), waited, o_rd, o_wr, o_addr, o_wd, g, nresp, ird, drd, st, to);
      model_update(seq[k], 1, 1, 1);
      checks++; if (to || g !== seq[k]) $display("FAIL starve_grant%0d got=%0d exp=%0d", k, g, seq[k]); else passes++;
      checks++; if (int'(dut.starve_cnt) !== m_bypass) $display("FAIL starve_cnt%0d got=%0d exp=%0d", k, dut.starve_cnt, m_bypass); else passes++;
      $display("starve txn %0d grant=%0d cnt=%0d", k, g, dut.starve_cnt);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_txn();
    int waited, g, nresp, n; logic o_rd, o_wr; logic [AW-1:0] o_addr; logic [LW-1:0] o_wd, ird, drd, rd; bit st, to;
    do_reset();
    bus.dcache_read = 1; bus.dcache_addr = 16'h2340;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.pmem_read && n < 20);
    checks++; if (bus.pmem_read !== 1) $display("FAIL midrst_grant got=%b exp=1", bus.pmem_read); else passes++;
    #2 reset = 1;
    #1;
    checks++; if (bus.pmem_read !== 0 || bus.pmem_address !== '0) $display("FAIL midrst_outputs got rd=%b addr=%h exp 0", bus.pmem_read, bus.pmem_address); else passes++;
    bus.pmem_resp = 1;
    #1;
    checks++; if (bus.dcache_resp !== 0) $display("FAIL midrst_noresp got=%b exp=0", bus.dcache_resp); else passes++;
    bus.pmem_resp = 0;
    @(posedge clk); #1 reset = 0;
    m_fav_d = 1; m_bypass = 0;
    rd = rand_line();
    serve(1, rd, waited, o_rd, o_wr, o_addr, o_wd, g, nresp, ird, drd, st, to);
    bus.dcache_read = 0;
    checks++; if (to || g !== G_D || o_addr !== 16'h2340 || drd !== rd) $display("FAIL midrst_regrant got g=%0d addr=%h exp g=%0d addr=2340", g, o_addr, G_D); else passes++;
    checks++; if (dut.rr_d !== m_fav_d) $display("FAIL midrst_rr got=%b exp=%b", dut.rr_d, m_fav_d); else passes++;
    $display("test_reset_mid_txn done");
  endtask

  task automatic test_random();
    int waited, g, nresp, exp; logic o_rd, o_wr; logic [AW-1:0] o_addr, exp_addr; logic [LW-1:0] o_wd, ird, drd, rd; bit st, to;
    bit pi = 0, pd = 0, pw = 0;
    logic [AW-1:0] ai = '0, ad = '0, aw = '0;
    logic [LW-1:0] wd = '0;
    int errs;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ai = rand_addr(); end
      if (!pd && $urandom_range(0, 1) == 1) begin pd = 1; ad = rand_addr(); end
      if (!pw && $urandom_range(0, 2) != 0) begin pw = 1; aw = rand_addr(); wd = rand_line(); end
      if (!pi && !pd && !pw) begin pd = 1; ad = rand_addr(); end
      bus.icache_read = pi; bus.icache_addr = ai;
      bus.dcache_read = pd; bus.dcache_addr = ad;
      bus.ewb_write = pw; bus.ewb_addr = aw; bus.ewb_wdata = wd;
      exp = predict(pi, pd, pw, ad, aw);
      exp_addr = (exp == G_I) ? ai : (exp == G_D) ? ad : aw;
      rd = rand_line();
      serve($urandom_range(0, 3), rd, waited, o_rd, o_wr, o_addr, o_wd, g, nresp, ird, drd, st, to);
      errs = 0;
      if (to || g !== exp || nresp !== 1) errs++;
      if (o_addr !== exp_addr || o_rd !== (exp != G_W) || o_wr !== (exp == G_W)) errs++;
      if (exp == G_W && o_wd !== wd) errs++;
      if (exp == G_I && (ird !== rd || drd !== '0)) errs++;
      if (exp == G_D && (drd !== rd || ird !== '0)) errs++;
      if (waited !== 2 || !st) errs++;
      checks++;
      if (errs != 0) $display("FAIL rand_txn%0d got g=%0d addr=%h wait=%0d exp g=%0d addr=%h wait=2", n, g, o_addr, waited, exp, exp_addr);
      else passes++;
      $display("rand txn %0d req=%b%b%b grant=%0d addr=%h", n, pi, pd, pw, g, o_addr);
      model_update(exp, pi, pd, pw);
      if (exp == G_I) pi = 0;
      if (exp == G_D) pd = 0;
      if (exp == G_W) pw = 0;
      bus.icache_read = pi; bus.dcache_read = pd; bus.ewb_write = pw;
    end
    drive_idle();
  endtask

  task automatic test_spurious();
    do_reset();
    @(posedge clk); #1 bus.pmem_resp = 1; bus.pmem_rdata = rand_line();
    @(negedge clk);
    checks++; if ({bus.icache_resp, bus.dcache_resp, bus.ewb_resp} !== 3'b000) $display("FAIL spurious_resp got=%b exp=000", {bus.icache_resp, bus.dcache_resp, bus.ewb_resp}); else passes++;
    @(posedge clk); #1 bus.pmem_resp = 0;
    @(negedge clk);
    checks++; if (bus.pmem_read !== 0 || bus.pmem_write !== 0) $display("FAIL spurious_state got=%b%b exp=00", bus.pmem_read, bus.pmem_write); else passes++;
    checks++; if (both_viol !== 0) $display("FAIL rd_wr_exclusive got=%0d exp=0", both_viol); else passes++;
    checks++; if (rdata_viol !== 0) $display("FAIL rdata_zero got=%0d exp=0", rdata_viol); else passes++;
    $display("test_spurious done");
  endtask

  initial begin
    drive_idle();
    m_fav_d = 1;
    m_bypass = 0;
    test_reset();
    test_single_iread();
    test_round_robin();
    test_hazard();
    test_starvation();
    test_reset_mid_txn();
    test_random();
    test_spurious();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
